// File: rtl/exa_crosb_pkg.sv
// Shared definitions for the crossbar input/output arbiters.
// Covers queue-index helpers, the arbiter FSM states and a constant log2.
package exa_crosb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1, so a 1-wide select never collapses to 0 bits.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned vp_index(input int unsigned prio, input int unsigned vc,
                                           input int unsigned vc_num);
    return prio * vc_num + vc;
  endfunction

  function automatic int unsigned vp_prio(input int unsigned k, input int unsigned vc_num);
    return k / vc_num;
  endfunction

  function automatic int unsigned vp_vc(input int unsigned k, input int unsigned vc_num);
    return k % vc_num;
  endfunction

endpackage

// File: rtl/ss_1h_to_b.sv
// One-hot to binary encoder; an all-zero input yields 0.
module ss_1h_to_b #(
  parameter int unsigned width    = 4,
  parameter int unsigned logWidth = 2
) (
  input  logic [width-1:0]    i_onehot,
  output logic [logWidth-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < width; i++) begin
      if (i_onehot[i]) o_bin = o_bin | logWidth'(i);
    end
  end

endmodule

// File: rtl/ss_out_rr.sv
// Round-robin picker: one-hot grant of the first request after the last served index.
// The pointer only advances when i_go accepts the current pick.
module ss_out_rr
  import exa_crosb_pkg::*;
#(
  parameter int unsigned input_num = 4,
  parameter int unsigned logInput  = log2(input_num)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [input_num-1:0] i_req,
  input  logic                 i_go,
  output logic [input_num-1:0] o_grant
);

  logic [logInput-1:0] r_ptr;
  logic [logInput-1:0] w_idx;
  logic                w_found;

  always_comb begin
    o_grant = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= input_num; i++) begin
      if (!w_found && i_req[logInput'((32'(r_ptr) + i) % input_num)]) begin
        w_found = 1'b1;
        w_idx   = logInput'((32'(r_ptr) + i) % input_num);
        o_grant[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_go && w_found) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/exa_crosb_input_arbiter_with_vcs.sv
// Input-side crossbar arbiter: requests outputs for queue heads, accepts one grant,
// then streams the chosen queue to the chosen output until the last flit.
module exa_crosb_input_arbiter_with_vcs
  import exa_crosb_pkg::*;
#(
  parameter int unsigned prio_num   = 2,
  parameter int unsigned vc_num     = 2,
  parameter int unsigned output_num = 4,
  parameter int unsigned logVcPrio  = log2(prio_num * vc_num),
  parameter int unsigned logOutput  = log2(output_num)
) (
  input  logic                                             clk,
  input  logic                                             resetn,
  input  logic [prio_num*vc_num-1:0]                       i_head_valid,
  input  logic [prio_num*vc_num-1:0][logOutput-1:0]        i_head_dest,
  input  logic [prio_num*vc_num-1:0]                       i_head_last,
  input  logic [output_num-1:0]                            i_out_ready,
  input  logic [output_num-1:0]                            i_grant,
  input  logic [output_num-1:0]                            i_out_cts,
  output logic [output_num-1:0][prio_num*vc_num-1:0]       o_request,
  output logic [output_num-1:0]                            o_cts,
  output logic [output_num-1:0]                            o_last,
  output logic [prio_num*vc_num-1:0]                       o_pop,
  output logic                                             o_valid,
  output logic [logOutput-1:0]                             o_out_sel,
  output logic [logVcPrio-1:0]                             o_vp_sel
);

  localparam int unsigned VP = prio_num * vc_num;

  state_t                          r_state, w_state_nxt;
  logic [logOutput-1:0]            r_sel_out;
  logic [logVcPrio-1:0]            r_sel_vp;

  logic [output_num-1:0][VP-1:0]   w_req_raw;
  logic [output_num-1:0]           w_has_req;
  logic [output_num-1:0]           w_g;
  logic                            w_go;
  logic [output_num-1:0]           w_rr_gnt;
  logic [logOutput-1:0]            w_out_bin;
  logic [logVcPrio-1:0]            w_vp_pick;
  logic                            w_fire;
  logic                            w_last_fire;

  always_comb begin
    w_req_raw = '0;
    w_has_req = '0;
    for (int unsigned o = 0; o < output_num; o++) begin
      for (int unsigned k = 0; k < VP; k++) begin
        if (i_head_valid[k] && (i_head_dest[k] == logOutput'(o))) w_req_raw[o][k] = 1'b1;
      end
      w_has_req[o] = |w_req_raw[o];
    end
  end

  // Grants for outputs we no longer have a head for are stale and dropped here.
  assign w_g  = i_grant & i_out_cts & w_has_req;
  assign w_go = resetn && (r_state == IDLE) && (|w_g);

  ss_out_rr #(
    .input_num (output_num),
    .logInput  (logOutput)
  ) u_out_rr (
    .clk     (clk),
    .resetn  (resetn),
    .i_req   (w_g),
    .i_go    (w_go),
    .o_grant (w_rr_gnt)
  );

  ss_1h_to_b #(
    .width    (output_num),
    .logWidth (logOutput)
  ) u_out_enc (
    .i_onehot (w_rr_gnt),
    .o_bin    (w_out_bin)
  );

  // Highest queue index wins, i.e. highest priority then highest VC.
  always_comb begin
    w_vp_pick = '0;
    for (int unsigned k = 0; k < VP; k++) begin
      if (w_req_raw[w_out_bin][k]) w_vp_pick = logVcPrio'(k);
    end
  end

  assign w_fire      = i_head_valid[r_sel_vp] & i_out_ready[r_sel_out];
  assign w_last_fire = w_fire & i_head_last[r_sel_vp];

  always_comb begin
    w_state_nxt = r_state;
    o_request   = '0;
    o_cts       = '0;
    o_last      = '0;
    o_pop       = '0;
    o_valid     = 1'b0;
    o_out_sel   = '0;
    o_vp_sel    = '0;
    case (r_state)
      IDLE: begin
        o_request = w_req_raw;
        if (|w_g) w_state_nxt = BUSY;
      end
      BUSY: begin
        o_cts[r_sel_out]  = 1'b1;
        o_pop[r_sel_vp]   = w_fire;
        o_valid           = w_fire;
        o_last[r_sel_out] = w_last_fire;
        o_out_sel         = r_sel_out;
        o_vp_sel          = r_sel_vp;
        if (w_last_fire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!resetn) begin
      o_request = '0;
      o_cts     = '0;
      o_last    = '0;
      o_pop     = '0;
      o_valid   = 1'b0;
      o_out_sel = '0;
      o_vp_sel  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_sel_out <= '0;
      r_sel_vp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_sel_out <= w_out_bin;
        r_sel_vp  <= w_vp_pick;
      end
    end
  end

endmodule

// File: tb/tb_exa_crosb_input_arbiter_with_vcs.sv
// Directed bench for the input arbiter: request table plus multi-cycle packet sequences.
module tb_exa_crosb_input_arbiter_with_vcs;

  logic             clk = 1'b0;
  logic             resetn;
  logic [3:0]       hv;
  logic [3:0][1:0]  hd;
  logic [3:0]       hl;
  logic [3:0]       rdy;
  logic [3:0]       gr;
  logic [3:0]       oc;
  logic [3:0][3:0]  o_request;
  logic [3:0]       o_cts;
  logic [3:0]       o_last;
  logic [3:0]       o_pop;
  logic             o_valid;
  logic [1:0]       o_out_sel;
  logic [1:0]       o_vp_sel;
  logic [32:0]      all_outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exa_crosb_input_arbiter_with_vcs #(
    .prio_num   (2),
    .vc_num     (2),
    .output_num (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_head_valid (hv),
    .i_head_dest  (hd),
    .i_head_last  (hl),
    .i_out_ready  (rdy),
    .i_grant      (gr),
    .i_out_cts    (oc),
    .o_request    (o_request),
    .o_cts        (o_cts),
    .o_last       (o_last),
    .o_pop        (o_pop),
    .o_valid      (o_valid),
    .o_out_sel    (o_out_sel),
    .o_vp_sel     (o_vp_sel)
  );

  assign all_outs = {o_request, o_cts, o_last, o_pop, o_valid, o_out_sel, o_vp_sel};

  typedef struct {
    logic [3:0]  hv;
    logic [7:0]  hd;
    logic [15:0] req;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; hv = '0; hd = '0; hl = '0; gr = '0; oc = '0; rdy = 4'hF;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{hv: 4'b0001, hd: 8'h01, req: 16'h0010};
    tbl[1] = '{hv: 4'b1111, hd: 8'hE4, req: 16'h8421};
    tbl[2] = '{hv: 4'b1010, hd: 8'hFF, req: 16'hA000};
    tbl[3] = '{hv: 4'b0101, hd: 8'hAA, req: 16'h0500};
    tbl[4] = '{hv: 4'b0000, hd: 8'hE4, req: 16'h0000};
    tbl[5] = '{hv: 4'b1100, hd: 8'h40, req: 16'h0084};

    // reset: everything quiet even with live heads and grants
    resetn = 1'b0; hv = 4'hF; hd = 8'hE4; hl = 4'hF; rdy = 4'hF; gr = 4'hF; oc = 4'hF;
    @(negedge clk); #1 chk("reset_outs_c0", 64'(all_outs), 0);
    @(negedge clk); #1 chk("reset_outs_c1", 64'(all_outs), 0);
    resetn = 1'b1; hv = '0; hl = '0; gr = '0; oc = '0;
    #1 chk("idle_after_reset", 64'(all_outs), 0);

    // table: IDLE request mapping without grants
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hv = tbl[i].hv; hd = tbl[i].hd;
      #1;
      chk($sformatf("tbl%0d_req", i), 64'(o_request), 64'(tbl[i].req));
      chk($sformatf("tbl%0d_cts", i), 64'(o_cts), 0);
    end

    // S1: queue 3 -> output 2, three flits
    @(negedge clk);
    hv = 4'b1000; hd = 8'h80; hl = 4'b0000; gr = 4'b0100; oc = 4'b0100;
    #1 chk("s1_T_cts", 64'(o_cts), 0);
    chk("s1_T_req", 64'(o_request), 16'h0800);
    @(negedge clk); gr = '0; oc = '0;
    #1 chk("s1_T1_cts", 64'(o_cts), 4'b0100);
    chk("s1_T1_pop", 64'(o_pop), 4'b1000);
    chk("s1_T1_sel", 64'({o_valid, o_out_sel, o_vp_sel}), 5'b1_10_11);
    chk("s1_T1_req", 64'(o_request), 0);
    chk("s1_T1_last", 64'(o_last), 0);
    @(negedge clk);
    #1 chk("s1_T2_pop", 64'(o_pop), 4'b1000);
    chk("s1_T2_req", 64'(o_request), 0);
    @(negedge clk); hl = 4'b1000;
    #1 chk("s1_T3_pop", 64'(o_pop), 4'b1000);
    chk("s1_T3_last", 64'(o_last), 4'b0100);
    chk("s1_T3_cts", 64'(o_cts), 4'b0100);
    @(negedge clk); hl = '0;
    #1 chk("s1_T4_cts", 64'(o_cts), 0);
    chk("s1_T4_req", 64'(o_request), 16'h0800);
    hv = '0;

    // S2: simultaneous grants, RR from pointer 0
    do_reset();
    hv = 4'b0101; hd = 8'h31; hl = 4'b0101; gr = 4'b1010; oc = 4'b1010;
    #1 chk("s2_T_cts", 64'(o_cts), 0);
    @(negedge clk);
    #1 chk("s2_T1_cts", 64'(o_cts), 4'b0010);
    chk("s2_T1_pop", 64'(o_pop), 4'b0001);
    chk("s2_T1_last", 64'(o_last), 4'b0010);
    @(negedge clk);
    #1 chk("s2_T2_cts", 64'(o_cts), 0);
    chk("s2_T2_req", 64'(o_request), 16'h4010);
    @(negedge clk);
    #1 chk("s2_T3_cts", 64'(o_cts), 4'b1000);
    chk("s2_T3_pop", 64'(o_pop), 4'b0100);
    chk("s2_T3_sel", 64'({o_out_sel, o_vp_sel}), 4'b11_10);
    @(negedge clk); hv = '0; gr = '0; oc = '0; hl = '0;

    // S3: queues 1 and 3 on output 0, highest index first; grant held throughout
    @(negedge clk);
    hv = 4'b1010; hd = 8'h00; hl = 4'b0000; gr = 4'b0001; oc = 4'b0001;
    #1 chk("s3_T_req", 64'(o_request), 16'h000A);
    @(negedge clk);
    #1 chk("s3_T1_vp", 64'(o_vp_sel), 2'd3);
    chk("s3_T1_pop", 64'(o_pop), 4'b1000);
    @(negedge clk); hl = 4'b1000;
    #1 chk("s3_T2_pop", 64'(o_pop), 4'b1000);
    chk("s3_T2_last", 64'(o_last), 4'b0001);
    @(negedge clk); hv = 4'b0010; hl = 4'b0010;
    #1 chk("s3_T3_cts", 64'(o_cts), 0);
    chk("s3_T3_req", 64'(o_request), 16'h0002);
    @(negedge clk);
    #1 chk("s3_T4_pop", 64'(o_pop), 4'b0010);
    chk("s3_T4_vp", 64'(o_vp_sel), 2'd1);
    @(negedge clk); hv = '0; hl = '0; gr = '0; oc = '0;

    // S4: output not ready for four BUSY cycles
    @(negedge clk);
    hv = 4'b0100; hd = 8'h10; hl = 4'b0100; gr = 4'b0010; oc = 4'b0010; rdy = 4'b1101;
    @(negedge clk); gr = '0; oc = '0;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("s4_stall%0d", c), 64'({o_cts, o_pop, o_valid, o_last}), 13'b0010_0000_0_0000);
      chk($sformatf("s4_stall%0d_req", c), 64'(o_request), 0);
      @(negedge clk);
    end
    rdy = 4'hF;
    #1 chk("s4_resume", 64'({o_cts, o_pop, o_valid, o_last}), 13'b0010_0100_1_0010);
    @(negedge clk);
    #1 chk("s4_idle_cts", 64'(o_cts), 0);
    hv = '0; hl = '0;

    // S5: grant for an output nobody targets
    @(negedge clk);
    hv = 4'b0001; hd = 8'h00; gr = 4'b0010; oc = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("s5_stale%0d", c), 64'({o_cts, o_request}), 20'h0_0001);
      @(negedge clk);
    end
    hv = '0; gr = '0; oc = '0;

    // S6: reset on the second flit of a packet
    @(negedge clk);
    hv = 4'b0001; hd = 8'h03; hl = 4'b0000; gr = 4'b1000; oc = 4'b1000;
    @(negedge clk); gr = '0; oc = '0;
    #1 chk("s6_flit1", 64'({o_cts, o_pop}), 8'b1000_0001);
    @(negedge clk); resetn = 1'b0; hl = 4'b0001;
    #1 chk("s6_rst_c0", 64'(all_outs), 0);
    @(negedge clk);
    #1 chk("s6_rst_c1", 64'(all_outs), 0);
    resetn = 1'b1; hl = '0;
    @(negedge clk);
    #1 chk("s6_idle", 64'({o_cts, o_last, o_request}), 24'h00_1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exa_crosb_input_arbiter_with_vcs.md
Name: exa_crosb_input_arbiter_with_VCs

Overview:
- Input-side arbiter for one crossbar input port. It is the counterpart of the per-output arbiters.
- Turns the heads of the port's (prio,vc) queues into per-output request vectors, collects the grants returned by the output arbiters, and accepts exactly one by asserting CTS to it.
- Streams the selected queue's flits until last, then releases the output and re-arbitrates.

Parameters:
- prio_num, 2, number of priority levels
- vc_num, 2, VCs per priority
- output_num, 4, crossbar outputs
- logVcPrio, log2(prio_num*vc_num), queue index width
- logOutput, log2(output_num), output index width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- i_head_valid  in  VP=prio_num*vc_num  queue k non-empty; k = prio*vc_num+vc
- i_head_dest  in  [VP-1:0][logOutput]  destination output of the head flit of queue k
- i_head_last  in  VP  head flit of queue k is the packet's last flit
- i_out_ready  in  output_num  output o can accept a flit this cycle
- i_grant  in  output_num  output arbiter o grants this input (its o_grant bit for this port)
- i_out_cts  in  output_num  o_cts of output arbiter o
- o_request  out  [output_num-1:0][VP]  request vector to each output arbiter
- o_cts  out  output_num  cts_from_input_arbiter to each output; one-hot or zero
- o_last  out  output_num  i_last to each output arbiter
- o_pop  out  VP  dequeue the head of queue k; one-hot or zero
- o_valid  out  1  a flit is transferred this cycle
- o_out_sel  out  logOutput  crossbar output mux select
- o_vp_sel  out  logVcPrio  queue mux select

Behaviour:
- FSM states: IDLE, BUSY. The state, sel_out_q and sel_vp_q are registered.
- Reset: state=IDLE, sel_out_q=0, sel_vp_q=0, RR pointer=0. All outputs are 0 while resetn=0.
- IDLE requests: o_request[o][k] = head_valid[k] & (head_dest[k]==o).
- BUSY requests: all o_request bits are 0. This stops other outputs from churning grants.
- IDLE grant evaluation:
  - Valid grant set g = i_grant & i_out_cts & has_req. has_req[o] is 1 when any queue with a valid head targets o.
  - Grants with no matching queue are stale and are ignored.
- IDLE selection when g != 0:
  - Pick the output from g by round-robin, starting after the last served output.
  - Within that output, pick the queue with the highest index k among those targeting it (highest prio wins; within a prio, the higher vc wins).
  - Latch both selections, advance the RR pointer, state goes to BUSY.
  - o_cts stays 0 in this cycle.
- Grant timing:
  - Output arbiter grant seen in cycle T gives o_cts[sel_out_q]=1 at T+1.
  - Every non-selected output sees cts=0 at T+1, so its arbiter returns to IDLE.
- BUSY cycle behaviour:
  - o_cts[sel_out_q]=1 in every BUSY cycle, including the cycle that carries last.
  - Transfer condition fire = head_valid[sel_vp_q] & i_out_ready[sel_out_q].
  - o_pop[sel_vp_q] = fire; o_valid = fire; o_last[sel_out_q] = fire & head_last[sel_vp_q].
  - o_out_sel and o_vp_sel drive the latched selections.
- BUSY to IDLE: occurs on the cycle after a fire with last. Requests reassert in the next cycle.
- Minimum packet occupancy: 2 cycles (grant cycle plus one BUSY cycle) for a single-flit packet.
- Bubbles: head_valid low or ready low in BUSY stalls the transfer. The block stays BUSY with CTS held; there is no timeout.
- Queue changes during a packet: head_dest or prio changes are not re-evaluated in BUSY; the selection stays locked until last.
- Simultaneous events: several grants in the same cycle resolve to exactly one CTS. A grant arriving while BUSY is ignored (no CTS).
- Reset mid-packet: IDLE next cycle, no o_last emitted. The upstream queue is flushed by its own reset.

Decomposition:
- Shared package (exa_crosb_pkg):
  - VP/index helper functions: vp_index(prio,vc) and split back.
  - FSM state enum {IDLE, BUSY}.
  - The log2 macro.
- Sub-module: reuse ss_out_rr (input_num=output_num, go = IDLE & g!=0) for output selection.
- Sub-module: reuse ss_1h_to_b for the one-hot to binary select conversion.

Test Plan:
- Queue k=3 (prio1,vc1) head to output 2, 3 flits; grant[2] & out_cts[2] at T.
  - o_cts=4'b0100 from T+1; o_pop[3] on T+1, T+2, T+3.
  - o_last[2] at T+3; IDLE at T+4 with o_request zero in T+1..T+3.
- Queue 0 to output 1 and queue 2 to output 3, grants 4'b1010 together, RR pointer 0.
  - o_cts=4'b0010 only; output 3 sees cts 0 at T+1.
  - After the packet, a repeated pair of grants is served by output 3.
- Queues 1 and 3 both to output 0, grant[0].
  - o_pop[3] selected (o_vp_sel=3); queue 1 is served only after queue 3's last.
- BUSY with i_out_ready[sel]=0 for 4 cycles.
  - No o_pop, o_cts held at 1, state stays BUSY; transfer resumes when ready=1.
- i_grant[1]=1 while no queue targets output 1 → o_cts stays 0 and the state stays IDLE.
- resetn=0 on the second flit of a 4-flit packet → all outputs 0 next cycle, state IDLE, no o_last.
